// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store front end: RV32 width codes and FSM states.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } mau_state_t;

endpackage

// File: rtl/load_align.sv
// Lane selection and sign/zero extension of a little-endian memory word for RV32 loads.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = '0;
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      default: byte_s = word[31:24];
    endcase
    half_s = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_W:    result = word;
      F3_BU:   result = {24'd0, byte_s};
      F3_HU:   result = {16'd0, half_s};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-addressed Memory: aligned word accesses, load
// extension, read-modify-write for sub-word stores, and alignment/funct3 error flagging.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mau_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic        write_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_illegal;
  logic        req_misal;
  logic        req_err;
  logic        rd_last;
  logic [31:0] load_ext;
  logic [31:0] store_word;

  // Sub-word stores replace one lane of the word read back; SW passes wdata through.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lo,
                                              input logic [2:0]  f3);
    logic [31:0] m;
    m = word;
    case (f3)
      F3_B: begin
        case (lo)
          2'd0:    m[7:0]   = wdata[7:0];
          2'd1:    m[15:8]  = wdata[7:0];
          2'd2:    m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (lo[1]) m[31:16] = wdata[15:0];
        else       m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  assign accept = req_valid & req_ready;

  always_comb begin
    if (req_write)
      req_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else
      req_illegal = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_err   = req_illegal | req_misal;
  end

  assign rd_last = (state == ST_RD) && (cnt == '0);

  load_align u_load_align (
    .word    (mem_dout),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .result  (load_ext)
  );

  assign store_word = merge_store(data_q, wdata_q, addr_q[1:0], f3_q);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_nx = ST_RESP;
          end else if (req_write && (req_funct3 == F3_W)) begin
            state_nx = ST_WR;
          end else begin
            state_nx = ST_RD;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      ST_RD: begin
        if (cnt == '0) state_nx = write_q ? ST_WR : ST_RESP;
        else           cnt_nx   = cnt - 1'b1;
      end
      ST_WR:   state_nx = ST_RESP;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (rd_last) begin
        data_q <= mem_dout;
        if (!write_q) rdata_q <= load_ext;
      end
    end
  end

  // Request fields are pure data and only meaningful after an accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_comb begin
    req_ready  = (state == ST_IDLE) && !reset;
    mem_read   = (state == ST_RD)   && !reset;
    mem_write  = (state == ST_WR)   && !reset;
    resp_valid = (state == ST_RESP) && !reset;
    mem_addr   = (mem_read || mem_write) ? {addr_q[31:2], 2'b00} : 32'd0;
    mem_din    = mem_write  ? store_word : 32'd0;
    resp_rdata = resp_valid ? rdata_q    : 32'd0;
    resp_err   = resp_valid & err_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a small word-addressed memory model.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  mem_access_unit #(.LATENCY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 256 words, preloaded once while pre_en is high.
  logic [31:0] mem [256];
  logic        pre_en = 1'b1;
  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[64] <= 32'h808182F3;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr[9:2]];

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Response monitor: pops one expectation per resp_valid pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected resp_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, " rdata"}, resp_rdata, e.rdata);
          chk({e.name, " err"}, {31'd0, resp_err}, {31'd0, e.err});
          chk({e.name, " resp cycle"}, cyc, e.cyc);
        end
      end
    end
  end

  // Memory pin monitor.
  int          wr_cnt = 0, rd_cnt = 0, wr_cyc = 0;
  logic [31:0] wr_din = 32'd0, wr_addr = 32'd0;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_write) begin
        wr_cnt++;
        wr_cyc  = cyc;
        wr_din  = mem_din;
        wr_addr = mem_addr;
      end
      if (mem_read) rd_cnt++;
    end
  end

  task automatic send(input string nm, input logic w, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee, input int lat,
                      input bit push, output int acc);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk({nm, " accept timeout"}, 32'd0, 32'd1);
    else if (push) exp_q.push_back('{nm, er, ee, acc + lat});
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      chk({nm, " response timeout"}, exp_q.size(), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string nm, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee, input int lat,
                     output int acc);
    send(nm, w, f3, a, wd, er, ee, lat, 1'b1, acc);
    req_valid = 1'b0;
    drain(nm);
  endtask

  initial begin
    int acc, acc2;
    repeat (3) @(posedge clk);
    #1;
    pre_en = 1'b0;
    @(negedge clk);
    chk("reset req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset mem_read", {31'd0, mem_read}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Loads with LATENCY=1: response two cycles after acceptance.
    txn("LB 0x100",  1'b0, F3_B,  32'h100, 32'd0, 32'hFFFFFFF3, 1'b0, 2, acc);
    txn("LBU 0x103", 1'b0, F3_BU, 32'h103, 32'd0, 32'h00000080, 1'b0, 2, acc);
    txn("LH 0x102",  1'b0, F3_H,  32'h102, 32'd0, 32'hFFFF8081, 1'b0, 2, acc);
    txn("LHU 0x100", 1'b0, F3_HU, 32'h100, 32'd0, 32'h000082F3, 1'b0, 2, acc);

    // SB read-modify-write.
    wr_cnt = 0;
    txn("SB 0x101", 1'b1, F3_B, 32'h101, 32'h123456AA, 32'd0, 1'b0, 3, acc);
    chk("SB write count", wr_cnt, 32'd1);
    chk("SB write cycle", wr_cyc, acc + 2);
    chk("SB mem_din", wr_din, 32'h8081AAF3);
    chk("SB mem_addr", wr_addr, 32'h100);
    txn("LW 0x100 after SB", 1'b0, F3_W, 32'h100, 32'd0, 32'h8081AAF3, 1'b0, 2, acc);

    // SW skips the read.
    wr_cnt = 0;
    rd_cnt = 0;
    txn("SW 0x104", 1'b1, F3_W, 32'h104, 32'hDEADBEEF, 32'd0, 1'b0, 2, acc);
    chk("SW read count", rd_cnt, 32'd0);
    chk("SW write count", wr_cnt, 32'd1);
    chk("SW write cycle", wr_cyc, acc + 1);
    chk("SW mem_addr", wr_addr, 32'h104);
    chk("SW mem word", mem[65], 32'hDEADBEEF);

    // Errors: no memory cycle, response next cycle.
    wr_cnt = 0;
    rd_cnt = 0;
    txn("LW 0x102 misaligned", 1'b0, F3_W, 32'h102, 32'd0, 32'd0, 1'b1, 1, acc);
    txn("SH 0x101 misaligned", 1'b1, F3_H, 32'h101, 32'hFFFF, 32'd0, 1'b1, 1, acc);
    txn("load f3=011", 1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 1'b1, 1, acc);
    txn("store f3=100", 1'b1, 3'b100, 32'h100, 32'h55, 32'd0, 1'b1, 1, acc);
    chk("error read count", rd_cnt, 32'd0);
    chk("error write count", wr_cnt, 32'd0);

    // Reset during the WR cycle of SH 0x102.
    wr_cnt = 0;
    send("SH 0x102 reset", 1'b1, F3_H, 32'h102, 32'h0000BEEF, 32'd0, 1'b0, 3, 1'b0, acc);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset-in-WR mem_write", {31'd0, mem_write}, 32'd0);
    chk("reset-in-WR req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after reset req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("reset-in-WR write count", wr_cnt, 32'd0);
    chk("reset-in-WR mem word", mem[64], 32'h8081AAF3);
    @(posedge clk);
    #1;

    // req_valid held high across two loads.
    send("LW 0x100 b2b", 1'b0, F3_W, 32'h100, 32'd0, 32'h8081AAF3, 1'b0, 2, 1'b1, acc);
    send("LW 0x104 b2b", 1'b0, F3_W, 32'h104, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b1, acc2);
    req_valid = 1'b0;
    chk("b2b accept spacing", acc2 - acc, 32'd3);
    drain("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Request-side front end for the word-addressed `Memory` of the multi-cycle core; sits between the datapath's load/store control and `Memory`'s `addr`/`din`/`mem_read`/`mem_write`/`dout` pins. Accepts one RV32 load/store per handshake and drives `Memory` with word-aligned accesses. Performs byte/half extraction with sign or zero extension, and read-modify-write merging for SB/SH. Flags misaligned or illegal requests without touching memory.

## Interface
- `LATENCY`, default 1: cycles `mem_read` is held before read data is sampled; must be at least 1.
- `reset`  in  1  synchronous, active-high reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high iff state IDLE and `reset` low.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 width code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte/half is used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned address or illegal funct3; valid with `resp_valid`.
- `mem_addr`  out  32  to `Memory.addr`: `{addr_q[31:2],2'b00}` in RD/WR, else 0.
- `mem_din`  out  32  to `Memory.din`: merged word in WR, else 0.
- `mem_read`  out  1  high only in RD.
- `mem_write`  out  1  high only in WR and `reset` low.
- `mem_dout`  in  32  from `Memory.dout`; combinational read data.

## Operation
- Handshake: a request is accepted on a rising edge where `req_valid & req_ready`. At that edge, `req_write`, `req_funct3`, `req_addr` and `req_wdata` are latched. Request inputs are ignored in every other cycle.
- Error check at acceptance:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Misaligned: H accesses with `addr[0]`=1; W accesses with `addr[1:0]`≠0.
  - Either condition sends the FSM to RESP with `resp_err`=1. No memory cycle is issued.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE goes to RD for loads, SB and SH; to WR for SW; to RESP on error.
  - RD is held for exactly LATENCY cycles using a down-counter. `mem_dout` is captured into `data_q` at the final RD edge. From RD, a load goes to RESP and SB/SH go to WR.
  - WR lasts one cycle, then goes to RESP.
  - RESP lasts one cycle, then goes to IDLE.
- Little-endian lanes: byte k is `[8k+7:8k]`, with k = `addr[1:0]`. Halfword is selected by `addr[1]`.
- Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- SB/SH merge: the selected lane of `data_q` is replaced by `req_wdata[7:0]` or `req_wdata[15:0]`; all other bytes are preserved.
- Reset values: state IDLE, counter 0, `data_q` 0. Every output is 0 during reset, including `req_ready`.
- Reset mid-operation from any state:
  - The next state is IDLE and no response is issued.
  - `mem_write` is gated by `reset`, so no write lands on the reset edge.

## Timing
- Cycle 0 is the acceptance cycle. `resp_valid` is asserted in:
  - Load: cycle LATENCY+1.
  - SW: cycle 2 (WR in cycle 1).
  - SB/SH: cycle LATENCY+2 (RD in cycles 1..LATENCY, WR in cycle LATENCY+1).
  - Error: cycle 1.
- `resp_rdata` and `resp_err` are registered and stable for the RESP cycle only.
- Throughput: `req_ready` is low from cycle 1 through RESP and returns high the cycle after RESP. Back-to-back requests are therefore separated by one IDLE cycle.

## Structure
- Package `mem_access_pkg` holds the funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state typedef `mau_state_t`.
- One combinational sub-module, `load_align`, takes (`word`, `addr[1:0]`, `funct3`) and produces the extended result. All merging and the FSM stay in the top module.

## Test plan
All scenarios use LATENCY=1 with word 0x808182F3 preloaded at 0x100.
- LB 0x100 -> 0xFFFFFFF3 with resp in cycle 2. LBU 0x103 -> 0x00000080. LH 0x102 -> 0xFFFF8081. LHU 0x100 -> 0x000082F3.
- SB 0x101 with wdata 0x123456AA -> `mem_write` high for exactly cycle 2 with `mem_din`=0x8081AAF3. Resp in cycle 3; a following LW 0x100 returns 0x8081AAF3.
- SW 0x104 with 0xDEADBEEF -> `mem_read` never high, WR in cycle 1, resp in cycle 2, `mem_addr`=0x104 during WR.
- LW 0x102 and SH 0x101 -> `resp_err`=1 and `resp_rdata`=0 in cycle 1. `mem_read` and `mem_write` are never asserted.
- `reset` asserted during the WR cycle of SH 0x102 -> memory word unchanged, no `resp_valid`, `req_ready`=1 the cycle after reset drops.
- `req_valid` held high with LW 0x100 then LW 0x104 -> two responses, with exactly one IDLE cycle between them.
